uart_ascii_rx: RTL
==================

UART_ASCII_RX -- requirements
Module: uart_ascii_rx

Interface
- REQ-001: Parameter CLK_FREQ, default 25000000; pixel clock frequency in Hz.
- REQ-002: Parameter BAUD, default 115200; serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), which SHALL be at least 4.
- REQ-003: Parameter ASCII_WIDTH, default 8; character code width.
- REQ-004: Parameter COLOR_WIDTH, default 4; colour index width, equal to (BUFFER_WIDTH-ASCII_WIDTH)/2 of the display buffer.
- REQ-005: Parameter DEFAULT_F, default 4'hF; foreground index after reset.
- REQ-006: Parameter DEFAULT_B, default 4'h0; background index after reset.
- REQ-007: clk_pix  input  1  sole clock; all logic SHALL run on its rising edge.
- REQ-008: rst_n  input  1  reset, synchronous and active-low.
- REQ-009: uart_rx  input  1  asynchronous serial line, 8N1, idles high.
- REQ-010: asciiWrite  output  ASCII_WIDTH  last accepted character code.
- REQ-011: dataReady  output  1  single-cycle strobe; asciiWrite is valid in the same cycle.
- REQ-012: colorIndexF  output  COLOR_WIDTH  current foreground index.
- REQ-013: colorIndexB  output  COLOR_WIDTH  current background index.
- REQ-014: frame_err  output  1  single-cycle strobe on a bad stop bit.

Function
- REQ-015: uart_rx SHALL pass through a 2-flop synchroniser; the receiver SHALL sample only the synchronised value (rx_s).
- REQ-016: Receiver FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
- REQ-017: IDLE -> START on rx_s = 0; a bit counter then loads CLKS_PER_BIT/2 - 1.
- REQ-018: START: when the counter expires, rx_s = 0 -> DATA; rx_s = 1 -> IDLE (glitch, no strobe).
- REQ-019: DATA: 8 samples taken every CLKS_PER_BIT cycles, LSB first, shifted into a byte register; after the 8th sample -> STOP.
- REQ-020: STOP: sample after CLKS_PER_BIT cycles. rx_s = 1 -> byte accepted, go to IDLE. rx_s = 0 -> frame_err pulses 1 cycle, byte discarded, go to WAIT_HIGH.
- REQ-021: WAIT_HIGH -> IDLE on the first cycle with rx_s = 1 (break/stuck-low protection).
- REQ-022: The parser SHALL have states NORMAL and ESC and SHALL act only on accepted bytes.
- REQ-023: NORMAL with byte = 8'h1B -> ESC; no dataReady.
- REQ-024: NORMAL with any other byte: asciiWrite <= byte and dataReady = 1, exactly 1 cycle after the stop-sample cycle.
- REQ-025: ESC with any byte b: colorIndexB <= b[7:4], colorIndexF <= b[3:0], return to NORMAL; no dataReady. Colours update 1 cycle after the stop-sample cycle.
- REQ-026: An ESC followed by 8'h1B SHALL set the colours to B=1, F=B (hex), not emit a character.
- REQ-027: A framing error SHALL NOT change the parser state; a pending ESC survives it.
- REQ-028: asciiWrite and the colour outputs SHALL hold their values between updates; dataReady is never high on 2 consecutive cycles.
- REQ-029: Colour changes SHALL take effect before the next character's dataReady, so every character written uses the colours in force when it arrives.

Reset
- REQ-030: When rst_n = 0 at a clock edge: FSM -> IDLE; parser -> NORMAL; synchroniser flops -> 1; asciiWrite = 0; dataReady = 0; frame_err = 0; colorIndexF = DEFAULT_F; colorIndexB = DEFAULT_B.
- REQ-031: Reset mid-frame SHALL abort the frame; no strobe results from that partial frame.

Verification
Bench parameters: CLK_FREQ=25000000, BAUD=1000000 (25 clocks per bit).
- REQ-032: Send 8'h41 with a valid stop bit -> exactly one dataReady pulse with asciiWrite = 8'h41, 1 cycle after the stop sample; frame_err stays 0.
- REQ-033: Send 8'h1B then 8'h2E, then 8'h5A -> after the 2nd byte colorIndexB = 2 and colorIndexF = E with no dataReady; the 3rd byte gives dataReady with asciiWrite = 8'h5A while the colours stay 2/E.
- REQ-034: Drive a 5-clock low glitch on an idle line -> no dataReady, no frame_err, FSM back in IDLE.
- REQ-035: Send 8'h55 with stop bit = 0, hold the line low for 100 clocks, then send 8'h42 -> one frame_err pulse, no strobe for 8'h55, then dataReady with asciiWrite = 8'h42.
- REQ-036: Assert rst_n = 0 for 1 clock during data bit 4 of 8'h33 -> no strobe; outputs at reset values (F = F, B = 0); the next valid byte 8'h31 is received normally.
- REQ-037: Send 20 back-to-back printable bytes (no idle gap) -> 20 dataReady pulses carrying the correct codes in order.

Source files
------------

// File: rtl/uart_ascii_rx.sv
// UART 8N1 receiver feeding a character/colour parser for a text display buffer.
// ESC (8'h1B) followed by one byte b loads background = b[7:4], foreground = b[3:0].
module uart_ascii_rx #(
  parameter int unsigned CLK_FREQ    = 25000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ASCII_WIDTH = 8,
  parameter int unsigned COLOR_WIDTH = 4,
  parameter logic [COLOR_WIDTH-1:0] DEFAULT_F = 4'hF,
  parameter logic [COLOR_WIDTH-1:0] DEFAULT_B = 4'h0
) (
  input  logic                   clk_pix,
  input  logic                   rst_n,
  input  logic                   uart_rx,
  output logic [ASCII_WIDTH-1:0] asciiWrite,
  output logic                   dataReady,
  output logic [COLOR_WIDTH-1:0] colorIndexF,
  output logic [COLOR_WIDTH-1:0] colorIndexB,
  output logic                   frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0] ESC_CODE = 8'h1B;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  logic                   rx_meta_q, rx_s_q;
  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   esc_q, esc_d;
  logic [ASCII_WIDTH-1:0] ascii_q, ascii_d;
  logic                   ready_q, ready_d;
  logic                   ferr_q, ferr_d;
  logic [COLOR_WIDTH-1:0] col_f_q, col_f_d;
  logic [COLOR_WIDTH-1:0] col_b_q, col_b_d;
  logic                   byte_ok;

  // Receiver FSM: half-bit start check, mid-bit data sampling, stop-bit validation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_ok = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            state_d = DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s_q) begin
            byte_ok = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Parser: plain bytes become characters, ESC arms a colour update for the next byte
  always_comb begin
    esc_d   = esc_q;
    ascii_d = ascii_q;
    ready_d = 1'b0;
    col_f_d = col_f_q;
    col_b_d = col_b_q;
    if (byte_ok) begin
      if (esc_q) begin
        col_b_d = COLOR_WIDTH'(shift_q[7:4]);
        col_f_d = COLOR_WIDTH'(shift_q[3:0]);
        esc_d   = 1'b0;
      end else if (shift_q == ESC_CODE) begin
        esc_d = 1'b1;
      end else begin
        ascii_d = ASCII_WIDTH'(shift_q);
        ready_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset; synchroniser resets to idle-high
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      esc_q     <= 1'b0;
      ascii_q   <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
      col_f_q   <= DEFAULT_F;
      col_b_q   <= DEFAULT_B;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      esc_q     <= esc_d;
      ascii_q   <= ascii_d;
      ready_q   <= ready_d;
      ferr_q    <= ferr_d;
      col_f_q   <= col_f_d;
      col_b_q   <= col_b_d;
    end
  end

  assign asciiWrite  = ascii_q;
  assign dataReady   = ready_q;
  assign colorIndexF = col_f_q;
  assign colorIndexB = col_b_q;
  assign frame_err   = ferr_q;

endmodule
